// File: rtl/switch_cmd_debounce.sv
// ============================================================================
// switch_cmd_debounce: push-button synchroniser, debouncer and long-press FSM.
// Optional evt_cnt press counter enabled by macro SWITCH_CMD_EVT_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_cmd_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int LONG_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       clr,
    output logic       state_req,
    output logic       sel,
    output logic       press_pulse
`ifdef SWITCH_CMD_EVT_CNT_EN
    ,
    output logic [7:0] evt_cnt
`endif
);

    typedef enum logic [2:0] {
        RELEASED   = 3'd0,
        PRESS_DB   = 3'd1,
        PRESSED    = 3'd2,
        LONG       = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // Synchroniser is deliberately outside the clr domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RELEASED;
            cnt         <= '0;
            state_req   <= 1'b0;
            sel         <= 1'b0;
            press_pulse <= 1'b0;
        end else if (clr) begin
            state       <= RELEASED;
            cnt         <= '0;
            state_req   <= 1'b0;
            sel         <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (btn_s) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state <= RELEASED;
                    end else if (cnt == DB_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        state_req   <= ~state_req;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state <= LONG;
                        sel   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                LONG: begin
                    if (!btn_s) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end
                end
                RELEASE_DB: begin
                    // A bounce back high resumes the held state without a new toggle.
                    if (btn_s) begin
                        state <= sel ? LONG : PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                        sel   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef SWITCH_CMD_EVT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_cnt <= 8'd0;
        end else if (clr) begin
            evt_cnt <= 8'd0;
        end else if (press_pulse) begin
            evt_cnt <= evt_cnt + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_cmd_debounce.sv
// ============================================================================
// tb_switch_cmd_debounce: directed bench with a run-length reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_cmd_debounce;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int LNG  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic clr = 1'b0;
    logic state_req;
    logic sel;
    logic press_pulse;
`ifdef SWITCH_CMD_EVT_CNT_EN
    logic [7:0] evt_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    switch_cmd_debounce #(
        .SYNC_STAGES(SYNC),
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LNG),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .clr        (clr),
        .state_req  (state_req),
        .sel        (sel),
        .press_pulse(press_pulse)
`ifdef SWITCH_CMD_EVT_CNT_EN
        ,
        .evt_cnt    (evt_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a press is accepted after DB+1 consecutive high samples
    // of the synchronised button; within a press, LNG+1 consecutive high samples
    // (the accepting sample counting as the first) raise sel; DB+1 consecutive
    // low samples end the press.
    logic [SYNC-1:0] m_sync;
    logic            m_s;
    logic            m_pressed, m_long, m_req, m_pulse;
    int              m_hi, m_lo;
    logic [7:0]      m_evt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sync = '0; m_pressed = 0; m_long = 0; m_req = 0; m_pulse = 0;
            m_hi = 0; m_lo = 0; m_evt = 8'd0;
        end else begin
            m_s    = m_sync[SYNC-1];
            m_sync = {m_sync[SYNC-2:0], btn_raw};
            if (clr) m_evt = 8'd0;
            else if (m_pulse) m_evt = m_evt + 8'd1;
            if (clr) begin
                m_pressed = 0; m_long = 0; m_req = 0; m_pulse = 0; m_hi = 0; m_lo = 0;
            end else begin
                m_pulse = 0;
                if (m_s) begin m_hi++; m_lo = 0; end
                else begin m_lo++; m_hi = 0; end
                if (!m_pressed) begin
                    if (m_hi == DB + 1) begin
                        m_pressed = 1; m_req = ~m_req; m_pulse = 1; m_hi = 1;
                    end
                end else begin
                    if (m_s && !m_long && m_hi == LNG + 1) m_long = 1;
                    if (!m_s && m_lo == DB + 1) begin m_pressed = 0; m_long = 0; end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_state_req", 32'(state_req), 32'(m_req));
        chk("cyc_sel", 32'(sel), 32'(m_long));
        chk("cyc_press_pulse", 32'(press_pulse), 32'(m_pulse));
`ifdef SWITCH_CMD_EVT_CNT_EN
        chk("cyc_evt_cnt", 32'(evt_cnt), 32'(m_evt));
`endif
        if (press_pulse === 1'b1) pulses++;
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_state_req", 32'(state_req), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_pulse", 32'(press_pulse), 0);
        rst = 1'b1;
        tick(3);

        // Clean press: accept at edge SYNC+DB = 6
        btn_raw = 1'b1;
        tick(1);
        tick(5);
        chk("clean_e5_pulse", 32'(press_pulse), 0);
        chk("clean_e5_req", 32'(state_req), 0);
        tick(1);
        chk("clean_e6_pulse", 32'(press_pulse), 1);
        chk("clean_e6_req", 32'(state_req), 1);
        tick(1);
        chk("clean_e7_pulse", 32'(press_pulse), 0);
        tick(2);
        btn_raw = 1'b0;
        tick(10);
        chk("clean_sel", 32'(sel), 0);
        chk("clean_pulses", 32'(pulses), 1);

        // Bounce: never stable long enough
        btn_raw = 1'b1; tick(3);
        btn_raw = 1'b0; tick(1);
        btn_raw = 1'b1; tick(3);
        btn_raw = 1'b0; tick(10);
        chk("bounce_pulses", 32'(pulses), 1);
        chk("bounce_req", 32'(state_req), 1);

        // Long press held 40 samples, then glitch, then release
        btn_raw = 1'b1;
        tick(1);
        tick(6);
        chk("long_e6_pulse", 32'(press_pulse), 1);
        chk("long_e6_req", 32'(state_req), 0);
        tick(15);
        chk("long_e21_sel", 32'(sel), 0);
        tick(1);
        chk("long_e22_sel", 32'(sel), 1);
        tick(17);
        btn_raw = 1'b0; tick(2);
        btn_raw = 1'b1; tick(10);
        chk("glitch_sel", 32'(sel), 1);
        chk("glitch_pulses", 32'(pulses), 2);
        btn_raw = 1'b0;
        tick(1);
        tick(5);
        chk("release_f5_sel", 32'(sel), 1);
        tick(1);
        chk("release_f6_sel", 32'(sel), 0);
        tick(5);

        // clr on the accepting edge
        btn_raw = 1'b1;
        tick(1);
        tick(5);
        clr = 1'b1;
        tick(1);
        chk("clr_e6_pulse", 32'(press_pulse), 0);
        chk("clr_e6_req", 32'(state_req), 0);
        clr = 1'b0;
        btn_raw = 1'b0;
        tick(10);
        chk("clr_pulses", 32'(pulses), 2);
        btn_raw = 1'b1; tick(10);
        chk("clr_repress_req", 32'(state_req), 1);
        chk("clr_repress_pulses", 32'(pulses), 3);
        btn_raw = 1'b0; tick(10);

        // Async reset mid-debounce
        btn_raw = 1'b1;
        tick(1);
        tick(3);
        #2 rst = 1'b0;
        #1 chk("arst_db_req", 32'(state_req), 0);
        chk("arst_db_sel", 32'(sel), 0);
        btn_raw = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(10);
        chk("arst_db_pulses", 32'(pulses), 3);

        // Async reset mid-pulse
        btn_raw = 1'b1;
        tick(1);
        tick(6);
        #2 rst = 1'b0;
        #1 chk("arst_pulse_pulse", 32'(press_pulse), 0);
        chk("arst_pulse_req", 32'(state_req), 0);
        btn_raw = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(10);
        chk("arst_pulse_pulses", 32'(pulses), 3);
        chk("arst_pulse_req2", 32'(state_req), 0);

        // 257 clean presses from reset
        rst = 1'b0; tick(2);
        rst = 1'b1; tick(2);
        pulses = 0;
        for (int i = 0; i < 257; i++) begin
            btn_raw = 1'b1; tick(10);
            btn_raw = 1'b0; tick(10);
        end
        chk("many_req", 32'(state_req), 1);
        chk("many_pulses", 32'(pulses), 257);
`ifdef SWITCH_CMD_EVT_CNT_EN
        chk("many_evt", 32'(evt_cnt), 1);
`endif

        // clr during the pulse cycle beats the counter increment
        btn_raw = 1'b1;
        tick(7);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_pulse_req", 32'(state_req), 0);
`ifdef SWITCH_CMD_EVT_CNT_EN
        chk("clr_pulse_evt", 32'(evt_cnt), 0);
`endif
        btn_raw = 1'b0;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
